// File: rtl/ec_point_add_double.sv
// Affine point add/double over GF(p): R = P1 + P2.
// Shared modular multiplier; inversion by binary extended Euclid.
module ec_point_add_double #(
  parameter int N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] p,
  input  logic [N-1:0] a,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] y1,
  input  logic         inf1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] y2,
  input  logic         inf2,
  output logic [N-1:0] x3,
  output logic [N-1:0] y3,
  output logic         inf3,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, CLASSIFY, INV, LAMBDA, XR, YR, DONE
  } state_t;

  state_t       state_q;
  logic [N-1:0] p_q, a_q;
  logic [N-1:0] x1_q, y1_q, x2_q, y2_q;
  logic         inf1_q, inf2_q;
  logic [N-1:0] num_q, lam_q, xr_q;
  logic [N-1:0] u_q, v_q, s_q, t_q;
  logic [N-1:0] rx_q, ry_q;
  logic         rinf_q;
  logic [N-1:0] x3_q, y3_q;
  logic         inf3_q, busy_q, done_q;

  logic [N-1:0] u_d, v_d, s_d, t_d;
  logic [N-1:0] mul_a, mul_b, mul_r;
  logic [N-1:0] dnum_d, dden_d;
  logic [N+1:0] dsum;
  logic [N:0]   dtwo;

  function automatic logic [N-1:0] mulmod(
    input logic [N-1:0] x,
    input logic [N-1:0] y,
    input logic [N-1:0] m
  );
    logic [2*N-1:0] pr;
    pr = {{N{1'b0}}, x} * {{N{1'b0}}, y};
    return N'(pr % {{N{1'b0}}, m});
  endfunction

  function automatic logic [N-1:0] submod(
    input logic [N-1:0] x,
    input logic [N-1:0] y,
    input logic [N-1:0] m
  );
    if (x >= y) return x - y;
    return x + (m - y);
  endfunction

  function automatic logic [N-1:0] half(
    input logic [N-1:0] x,
    input logic [N-1:0] m
  );
    logic [N:0] s;
    s = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
    return s[N:1];
  endfunction

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      CLASSIFY: begin
        mul_a = x1_q;
        mul_b = x1_q;
      end
      LAMBDA: begin
        mul_a = num_q;
        mul_b = lam_q;
      end
      XR: begin
        mul_a = lam_q;
        mul_b = lam_q;
      end
      YR: begin
        mul_a = lam_q;
        mul_b = submod(x1_q, xr_q, p_q);
      end
      default: ;
    endcase
    mul_r = mulmod(mul_a, mul_b, p_q);
  end

  // Doubling slope terms: 3*x1^2 + a and 2*y1, each reduced once
  always_comb begin
    dsum = {2'b00, mul_r} + {1'b0, mul_r, 1'b0}
         + {2'b00, a_q};
    dnum_d = N'(dsum % {2'b00, p_q});
    dtwo = {y1_q, 1'b0};
    if (dtwo >= {1'b0, p_q})
      dtwo = dtwo - {1'b0, p_q};
    dden_d = dtwo[N-1:0];
  end

  // Invariants: s*den == u, t*den == v (mod p)
  always_comb begin
    u_d = u_q;
    v_d = v_q;
    s_d = s_q;
    t_d = t_q;
    unique case (1'b1)
      !u_q[0]: begin
        u_d = u_q >> 1;
        s_d = half(s_q, p_q);
      end
      u_q[0] && !v_q[0]: begin
        v_d = v_q >> 1;
        t_d = half(t_q, p_q);
      end
      u_q[0] && v_q[0] && (u_q >= v_q): begin
        u_d = (u_q - v_q) >> 1;
        s_d = half(submod(s_q, t_q, p_q), p_q);
      end
      u_q[0] && v_q[0] && (u_q < v_q): begin
        v_d = (v_q - u_q) >> 1;
        t_d = half(submod(t_q, s_q, p_q), p_q);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      inf1_q  <= 1'b0;
      inf2_q  <= 1'b0;
      num_q   <= '0;
      lam_q   <= '0;
      xr_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rinf_q  <= 1'b0;
      x3_q    <= '0;
      y3_q    <= '0;
      inf3_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            p_q     <= p;
            a_q     <= a;
            x1_q    <= x1;
            y1_q    <= y1;
            inf1_q  <= inf1;
            x2_q    <= x2;
            y2_q    <= y2;
            inf2_q  <= inf2;
            busy_q  <= 1'b1;
            state_q <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          v_q <= p_q;
          s_q <= {{(N-1){1'b0}}, 1'b1};
          t_q <= '0;
          if (inf1_q) begin
            rx_q    <= inf2_q ? '0 : x2_q;
            ry_q    <= inf2_q ? '0 : y2_q;
            rinf_q  <= inf2_q;
            state_q <= DONE;
          end else if (inf2_q) begin
            rx_q    <= x1_q;
            ry_q    <= y1_q;
            rinf_q  <= 1'b0;
            state_q <= DONE;
          end else if (x1_q == x2_q &&
                       (y1_q != y2_q || y1_q == '0)) begin
            rx_q    <= '0;
            ry_q    <= '0;
            rinf_q  <= 1'b1;
            state_q <= DONE;
          end else if (x1_q == x2_q) begin
            num_q   <= dnum_d;
            u_q     <= dden_d;
            state_q <= INV;
          end else begin
            num_q   <= submod(y2_q, y1_q, p_q);
            u_q     <= submod(x2_q, x1_q, p_q);
            state_q <= INV;
          end
        end
        INV: begin
          if (u_q == {{(N-1){1'b0}}, 1'b1}) begin
            lam_q   <= s_q;
            state_q <= LAMBDA;
          end else if (v_q == {{(N-1){1'b0}}, 1'b1}) begin
            lam_q   <= t_q;
            state_q <= LAMBDA;
          end else begin
            u_q <= u_d;
            v_q <= v_d;
            s_q <= s_d;
            t_q <= t_d;
          end
        end
        LAMBDA: begin
          lam_q   <= mul_r;
          state_q <= XR;
        end
        XR: begin
          xr_q <= submod(submod(mul_r, x1_q, p_q),
                         x2_q, p_q);
          state_q <= YR;
        end
        YR: begin
          rx_q    <= xr_q;
          ry_q    <= submod(mul_r, y1_q, p_q);
          rinf_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE: begin
          x3_q    <= rx_q;
          y3_q    <= ry_q;
          inf3_q  <= rinf_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x3   = x3_q;
  assign y3   = y3_q;
  assign inf3 = inf3_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ec_point_add_double.sv
// Directed scoreboard bench for ec_point_add_double on
// y^2 = x^3 + 2x + 2 over GF(17), generator (5,1).
module tb_ec_point_add_double;

  localparam int N = 231;
  localparam int MAXLAT = 2 * N + 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] p = '0, a = '0;
  logic [N-1:0] x1 = '0, y1 = '0;
  logic [N-1:0] x2 = '0, y2 = '0;
  logic         inf1 = 1'b0, inf2 = 1'b0;
  logic [N-1:0] x3, y3;
  logic         inf3, busy, done;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
    int           cyc0;
    bit           exact3;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   lat;
  int   checks = 0;
  int   errors = 0;

  ec_point_add_double #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .p(p), .a(a),
    .x1(x1), .y1(y1), .inf1(inf1),
    .x2(x2), .y2(y2), .inf2(inf2),
    .x3(x3), .y3(y3), .inf3(inf3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got x=%0d y=%0d inf=%0d want none",
                 x3, y3, inf3);
      end else begin
        e = exp_q.pop_front();
        if (x3 !== e.x || y3 !== e.y || inf3 !== e.inf) begin
          errors++;
          $display("FAIL result got (%0d,%0d,inf=%0d) want (%0d,%0d,inf=%0d)",
                   x3, y3, inf3, e.x, e.y, e.inf);
        end
        lat = cyc - e.cyc0;
        checks++;
        if (e.exact3 ? (lat != 3) : (lat < 4 || lat > MAXLAT)) begin
          errors++;
          $display("FAIL latency got %0d want %s", lat,
                   e.exact3 ? "3" : "4..2N+6");
        end
      end
    end
  end

  task automatic drive(
    input logic [N-1:0] ax1, ay1, input logic ai1,
    input logic [N-1:0] ax2, ay2, input logic ai2
  );
    p = N'(17);
    a = N'(2);
    x1 = ax1; y1 = ay1; inf1 = ai1;
    x2 = ax2; y2 = ay2; inf2 = ai2;
    start = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < MAXLAT + 20 && !done; i++)
      @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s got no done want done", tag);
      exp_q.delete();
    end
  endtask

  task automatic run_op(
    input logic [N-1:0] ax1, ay1, input logic ai1,
    input logic [N-1:0] ax2, ay2, input logic ai2,
    input logic [N-1:0] ex, ey, input logic einf,
    input bit exact3
  );
    exp_t t;
    @(negedge clk);
    drive(ax1, ay1, ai1, ax2, ay2, ai2);
    t.x = ex; t.y = ey; t.inf = einf;
    t.cyc0 = cyc; t.exact3 = exact3;
    exp_q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    wait_done("op");
  endtask

  task automatic chk(input string nm, input logic [N-1:0] got,
                     input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    exp_t t;
    bit   hold_bad;
    repeat (3) @(negedge clk);
    chk("reset_busy", N'(busy), '0);
    chk("reset_done", N'(done), '0);
    chk("reset_x3", x3, '0);
    chk("reset_y3", y3, '0);
    chk("reset_inf3", N'(inf3), '0);
    reset = 1'b1;

    run_op(5, 1, 0, 5, 1, 0, 6, 3, 0, 0);
    run_op(5, 1, 0, 6, 3, 0, 10, 6, 0, 0);
    run_op(6, 3, 0, 5, 1, 0, 10, 6, 0, 0);
    run_op(5, 1, 0, 5, 16, 0, 0, 0, 1, 1);
    run_op(9, 9, 1, 5, 1, 0, 5, 1, 0, 1);
    run_op(9, 9, 1, 5, 1, 1, 0, 0, 1, 1);
    run_op(10, 6, 0, 3, 3, 1, 10, 6, 0, 1);
    run_op(4, 0, 0, 4, 0, 0, 0, 0, 1, 1);
    run_op(3, 1, 0, 9, 16, 0, 7, 6, 0, 0);
    run_op(10, 6, 0, 10, 6, 0, 16, 13, 0, 0);
    run_op(7, 6, 0, 7, 6, 0, 5, 16, 0, 0);
    run_op(0, 6, 0, 0, 11, 0, 0, 0, 1, 1);

    // Operand and start churn while busy must not disturb the result
    @(negedge clk);
    drive(5, 1, 0, 6, 3, 0);
    t.x = 10; t.y = 6; t.inf = 0;
    t.cyc0 = cyc; t.exact3 = 0;
    exp_q.push_back(t);
    hold_bad = 0;
    @(negedge clk);
    for (int i = 0; i < MAXLAT + 20 && busy; i++) begin
      start = 1'($urandom);
      x1 = N'($urandom_range(0, 16));
      y1 = N'($urandom_range(0, 16));
      x2 = N'($urandom_range(0, 16));
      y2 = N'($urandom_range(0, 16));
      inf1 = 1'($urandom);
      inf2 = 1'($urandom);
      p = N'($urandom_range(5, 31) | 1);
      a = N'($urandom_range(0, 4));
      if (x3 !== '0 || y3 !== '0 || inf3 !== 1'b1)
        hold_bad = 1;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL output_hold got changed outputs want (0,0,inf=1)");
    end
    wait_done("churn");
    repeat (4) @(negedge clk);

    // Abort in the middle of the inversion
    drive(7, 6, 0, 7, 6, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_x3", x3, '0);
    chk("abort_y3", y3, '0);
    chk("abort_inf3", N'(inf3), '0);
    chk("abort_busy", N'(busy), '0);
    chk("abort_done", N'(done), '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_nodone_x3", x3, '0);

    run_op(5, 1, 0, 5, 1, 0, 6, 3, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", N'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ec_point_add_double.md
EC_POINT_ADD_DOUBLE -- requirements
Module: ec_point_add_double

Interface
REQ-001 Parameter N, default 231: width of field elements, coordinates and modulus.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 p  in  N  odd prime modulus; p > 3.
REQ-006 a  in  N  curve coefficient a of y^2 = x^3 + a*x + b; a < p.
REQ-007 x1, y1  in  N each  operand P1 affine coordinates, < p.
REQ-008 inf1  in  1  P1 is the point at infinity; x1/y1 ignored when high.
REQ-009 x2, y2  in  N each  operand P2 affine coordinates, < p.
REQ-010 inf2  in  1  P2 is the point at infinity; x2/y2 ignored when high.
REQ-011 x3, y3  out  N each  result R = P1 + P2 coordinates; 0 when inf3 high.
REQ-012 inf3  out  1  result is the point at infinity.
REQ-013 busy  out  1  high while an operation is in progress.
REQ-014 done  out  1  one-cycle pulse: x3/y3/inf3 valid.

Function
REQ-015 States SHALL be IDLE, CLASSIFY, INV, LAMBDA, XR, YR, DONE.
REQ-016 IDLE with start=1 SHALL latch p, a, x1, y1, inf1, x2, y2, inf2 into internal registers, go to CLASSIFY, and raise busy the following cycle.
REQ-017 Input ports SHALL be ignored after the latch; changes to them during an operation SHALL NOT affect the result.
REQ-018 start while busy=1 or in DONE SHALL be ignored: no restart, no queuing.
REQ-019 CLASSIFY, in priority order: inf1 -> R=P2; else inf2 -> R=P1; else x1==x2 and (y1!=y2 or y1==0) -> R=infinity; all three go directly to DONE.
REQ-020 CLASSIFY otherwise: x1==x2, y1==y2 -> doubling, num=(3*x1^2+a) mod p, den=(2*y1) mod p; else addition, num=(y2-y1) mod p, den=(x2-x1) mod p; go to INV.
REQ-021 Modular subtraction SHALL add p when the minuend is smaller; no result SHALL ever be >= p.
REQ-022 Products SHALL be formed at full 2N width before reduction mod p; sums at N+2 width before reduction.
REQ-023 INV SHALL compute den^-1 mod p by iterative binary extended Euclid, one reduction step per cycle; it SHALL complete in at most 2N cycles, then go to LAMBDA.
REQ-024 LAMBDA: lambda = num*den^-1 mod p, one cycle.
REQ-025 XR: xr = (lambda^2 - x1 - x2) mod p, one cycle.
REQ-026 YR: yr = (lambda*(x1 - xr) - y1) mod p, one cycle; then DONE.
REQ-027 DONE SHALL update x3/y3/inf3, assert done for exactly one cycle, drop busy in the same cycle, and return to IDLE.
REQ-028 x3/y3/inf3 SHALL hold their values from DONE until the next DONE; they SHALL NOT change during an operation.
REQ-029 Infinity results SHALL drive inf3=1 and x3=y3=0; no high-impedance or X values SHALL appear on any output.
REQ-030 Total latency from start to done SHALL be 3 cycles for infinity/passthrough cases and at most 2N+6 cycles otherwise.
REQ-031 Back-to-back: start asserted in the cycle after done SHALL be accepted.

Reset
REQ-032 reset=0 SHALL force state=IDLE, busy=0, done=0, x3=0, y3=0, inf3=0, and clear all internal registers, asynchronously.
REQ-033 Reset during any state SHALL abort the operation with no done pulse; first start after reset release SHALL behave as from power-up.

Verification
REQ-034 p=17, a=2, P1=P2=(5,1) -> done, x3=6, y3=3, inf3=0, latency <= 2N+6.
REQ-035 p=17, a=2, P1=(5,1), P2=(6,3) -> x3=10, y3=6, inf3=0; repeat with P1 and P2 swapped -> identical result.
REQ-036 p=17, P1=(5,1), P2=(5,16) -> inf3=1, x3=y3=0, done 3 cycles after start.
REQ-037 inf1=1, P2=(5,1) -> x3=5, y3=1, inf3=0; then inf1=inf2=1 -> inf3=1; both at 3-cycle latency.
REQ-038 Start (5,1)+(6,3); toggle start and all operand ports while busy -> single done, result (10,6); then pull reset low mid-INV -> outputs 0 immediately, no done, next start (5,1)+(5,1) -> (6,3).
REQ-039 N=231 random regression: random P1=k1*G, P2=k2*G on a 231-bit curve vs reference model; every result matches and lies on the curve.
